ball_motion_sequencer: RTL and testbench

- Per-frame motion controller downstream of the collision detector.
- Captures the ball-collision and bat-angle codes raised during a frame and applies exactly one velocity update per frame at startOfFrame.
- Sequences serve, play, life-loss and game-over phases.
- Drives the signed X/Y speed consumed by the ball position block.

---
 rtl/motion_pkg.sv | 29 ++
 rtl/frame_event_latch.sv | 43 ++++
 rtl/ball_motion_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_ball_motion_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// Shared types and constants for the ball motion sequencer.
// Imported by the sequencer top and its frame event latch.
package motion_pkg;

  typedef enum logic [1:0] {
    SERVE,
    PLAY,
    LOST,
    GAME_OVER
  } state_t;

  typedef logic signed [10:0] speed_t;

  localparam int RIGHT  = 3;
  localparam int LEFT   = 2;
  localparam int TOP    = 1;
  localparam int BOTTOM = 0;

  // X speed per bat zone; index 0 is "no bat hit"
  localparam speed_t ZONE_X [8] = '{
    11'sd0, -11'sd4, -11'sd3, -11'sd2,
    11'sd0, 11'sd2, 11'sd3, 11'sd4
  };

  function automatic speed_t abs_s(input speed_t v);
    return v[10] ? -v : v;
  endfunction

endpackage

// File: rtl/frame_event_latch.sv
// Accumulates side-hit bits and the last bat zone within a frame.
// A clear keeps any event arriving in the same cycle.
module frame_event_latch
  import motion_pkg::*;
(
  input  logic       clk,
  input  logic       resetN,
  input  logic       i_en,
  input  logic       i_clear,
  input  logic [4:0] i_ballCollision,
  input  logic [2:0] i_batCollision,
  output logic [3:0] o_side,
  output logic [2:0] o_zone
);

  logic [3:0] r_side;
  logic [2:0] r_zone;
  logic [3:0] w_side_in;

  assign w_side_in = i_ballCollision[4] ?
                     i_ballCollision[3:0] : 4'd0;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_side <= 4'd0;
      r_zone <= 3'd0;
    end else if (!i_en) begin
      r_side <= 4'd0;
      r_zone <= 3'd0;
    end else if (i_clear) begin
      r_side <= w_side_in;
      r_zone <= i_batCollision;
    end else begin
      r_side <= r_side | w_side_in;
      if (i_batCollision != 3'd0)
        r_zone <= i_batCollision;
    end
  end

  assign o_side = r_side;
  assign o_zone = r_zone;

endmodule

// File: rtl/ball_motion_sequencer.sv
// Per-frame ball motion FSM: serve, play, life loss, game over.
// Applies one latched velocity update at each startOfFrame.
module ball_motion_sequencer
  import motion_pkg::*;
#(
  parameter int INIT_LIVES   = 3,
  parameter int BASE_Y       = 3,
  parameter int MAX_Y        = 7,
  parameter int SPEEDUP_HITS = 8,
  parameter int LOST_FRAMES  = 60
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [4:0]         ballCollision,
  input  logic [2:0]         batCollision,
  input  logic               ballLost,
  input  logic               launchReq,
  input  logic               newGame,
  output logic signed [10:0] speedX,
  output logic signed [10:0] speedY,
  output logic               ballOnBat,
  output logic [2:0]         livesLeft,
  output logic               gameOver
);

  localparam logic [2:0] LIVES0   = 3'(INIT_LIVES);
  localparam logic [3:0] BASE_M   = 4'(BASE_Y);
  localparam logic [3:0] MAX_M    = 4'(MAX_Y);
  localparam logic [7:0] HITS_N   = 8'(SPEEDUP_HITS);
  localparam logic [7:0] FRAMES_N = 8'(LOST_FRAMES);

  state_t     r_state;
  speed_t     r_speedX;
  speed_t     r_speedY;
  logic       r_ballOnBat;
  logic [2:0] r_lives;
  logic       r_gameOver;
  logic [7:0] r_hits;
  logic [3:0] r_magY;
  logic [7:0] r_frames;

  logic       w_latch_en;
  logic [3:0] w_side;
  logic [2:0] w_zone;
  logic [4:0] w_mag_raw;
  logic [4:0] w_mag;
  speed_t     w_bat_y;
  speed_t     w_serve_y;
  speed_t     w_nx;
  speed_t     w_ny;
  logic [3:0] w_mag_up;
  logic [7:0] w_hits_inc;

  assign w_latch_en = (r_state == PLAY) && !ballLost;

  frame_event_latch u_latch (
    .clk             (clk),
    .resetN          (resetN),
    .i_en            (w_latch_en),
    .i_clear         (startOfFrame),
    .i_ballCollision (ballCollision),
    .i_batCollision  (batCollision),
    .o_side          (w_side),
    .o_zone          (w_zone)
  );

  // Edge zones flatten the bounce, centre zones steepen it
  always_comb begin
    w_mag_raw = {1'b0, r_magY};
    unique case (1'b1)
      (w_zone == 3'd1) || (w_zone == 3'd7):
        w_mag_raw = {1'b0, r_magY} - 5'd1;
      (w_zone >= 3'd3) && (w_zone <= 3'd5):
        w_mag_raw = {1'b0, r_magY} + 5'd1;
      default: ;
    endcase
    w_mag = w_mag_raw;
    if (w_mag_raw == 5'd0)
      w_mag = 5'd1;
    else if (w_mag_raw > {1'b0, MAX_M})
      w_mag = {1'b0, MAX_M};
  end

  assign w_bat_y    = -(speed_t'({6'd0, w_mag}));
  assign w_serve_y  = -(speed_t'({7'd0, r_magY}));
  assign w_mag_up   = (r_magY < MAX_M) ? r_magY + 4'd1 : MAX_M;
  assign w_hits_inc = r_hits + 8'd1;

  always_comb begin
    w_nx = r_speedX;
    w_ny = r_speedY;
    if (w_zone != 3'd0) begin
      w_nx = ZONE_X[w_zone];
      w_ny = w_bat_y;
    end else begin
      if (w_side[RIGHT] && w_side[LEFT])
        w_nx = -r_speedX;
      else if (w_side[RIGHT])
        w_nx = abs_s(r_speedX);
      else if (w_side[LEFT])
        w_nx = -abs_s(r_speedX);
      if (w_side[TOP] && w_side[BOTTOM])
        w_ny = -r_speedY;
      else if (w_side[TOP])
        w_ny = -abs_s(r_speedY);
      else if (w_side[BOTTOM])
        w_ny = abs_s(r_speedY);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= SERVE;
      r_speedX    <= '0;
      r_speedY    <= '0;
      r_ballOnBat <= 1'b1;
      r_lives     <= LIVES0;
      r_gameOver  <= 1'b0;
      r_hits      <= 8'd0;
      r_magY      <= BASE_M;
      r_frames    <= 8'd0;
    end else begin
      unique case (r_state)
        SERVE: begin
          r_speedX    <= '0;
          r_speedY    <= '0;
          r_ballOnBat <= 1'b1;
          if (startOfFrame && launchReq) begin
            r_state     <= PLAY;
            r_speedX    <= 11'sd2;
            r_speedY    <= w_serve_y;
            r_ballOnBat <= 1'b0;
          end
        end
        PLAY: begin
          if (ballLost) begin
            r_lives  <= r_lives - 3'd1;
            r_speedX <= '0;
            r_speedY <= '0;
            r_frames <= 8'd0;
            if (r_lives == 3'd1) begin
              r_state    <= GAME_OVER;
              r_gameOver <= 1'b1;
            end else begin
              r_state <= LOST;
            end
          end else if (startOfFrame) begin
            r_speedX <= w_nx;
            r_speedY <= w_ny;
            if (w_zone != 3'd0) begin
              if (w_hits_inc >= HITS_N) begin
                r_hits <= 8'd0;
                r_magY <= w_mag_up;
              end else begin
                r_hits <= w_hits_inc;
              end
            end
          end
        end
        LOST: begin
          if (startOfFrame) begin
            if (r_frames + 8'd1 >= FRAMES_N) begin
              r_state     <= SERVE;
              r_ballOnBat <= 1'b1;
              r_magY      <= BASE_M;
              r_hits      <= 8'd0;
              r_frames    <= 8'd0;
            end else begin
              r_frames <= r_frames + 8'd1;
            end
          end
        end
        GAME_OVER: begin
          r_gameOver  <= 1'b1;
          r_speedX    <= '0;
          r_speedY    <= '0;
          r_ballOnBat <= 1'b0;
          if (newGame) begin
            r_state     <= SERVE;
            r_lives     <= LIVES0;
            r_gameOver  <= 1'b0;
            r_ballOnBat <= 1'b1;
            r_magY      <= BASE_M;
            r_hits      <= 8'd0;
          end
        end
        default: r_state <= SERVE;
      endcase
    end
  end

  assign speedX    = r_speedX;
  assign speedY    = r_speedY;
  assign ballOnBat = r_ballOnBat;
  assign livesLeft = r_lives;
  assign gameOver  = r_gameOver;

endmodule

// File: tb/tb_ball_motion_sequencer.sv
// Directed vector bench for ball_motion_sequencer.
// Table vectors plus hand sequences for speed-up, lives and reset.
module tb_ball_motion_sequencer;

  logic               clk = 1'b0;
  logic               resetN = 1'b1;
  logic               startOfFrame = 1'b0;
  logic [4:0]         ballCollision = '0;
  logic [2:0]         batCollision = '0;
  logic               ballLost = 1'b0;
  logic               launchReq = 1'b0;
  logic               newGame = 1'b0;
  logic signed [10:0] speedX;
  logic signed [10:0] speedY;
  logic               ballOnBat;
  logic [2:0]         livesLeft;
  logic               gameOver;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int sof; int ball; int bat;
    int lost; int launch; int ng;
    int ex; int ey; int eob; int el; int ego;
  } vec_t;

  vec_t vecs[$];

  ball_motion_sequencer dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .ballCollision (ballCollision),
    .batCollision  (batCollision),
    .ballLost      (ballLost),
    .launchReq     (launchReq),
    .newGame       (newGame),
    .speedX        (speedX),
    .speedY        (speedY),
    .ballOnBat     (ballOnBat),
    .livesLeft     (livesLeft),
    .gameOver      (gameOver)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input int sof, input int ball, input int bat,
    input int lost, input int launch, input int ng,
    input int ex, input int ey, input int eob,
    input int el, input int ego);
    vec_t t;
    t = '{sof, ball, bat, lost, launch, ng,
          ex, ey, eob, el, ego};
    return t;
  endfunction

  function automatic vec_t pv(
    input int sof, input int ball, input int bat,
    input int ex, input int ey);
    return mk(sof, ball, bat, 0, 0, 0, ex, ey, 0, 3, 0);
  endfunction

  task automatic step(
    input int sof, input int ball, input int bat,
    input int lost, input int launch, input int ng);
    @(negedge clk);
    startOfFrame  = 1'(sof);
    ballCollision = 5'(ball);
    batCollision  = 3'(bat);
    ballLost      = 1'(lost);
    launchReq     = 1'(launch);
    newGame       = 1'(ng);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string nm, input int ex, input int ey,
    input int eob, input int el, input int ego);
    checks++;
    if (speedX !== 11'(ex) || speedY !== 11'(ey) ||
        ballOnBat !== 1'(eob) || livesLeft !== 3'(el) ||
        gameOver !== 1'(ego)) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d bat=%0b lives=%0d go=%0b want x=%0d y=%0d bat=%0d lives=%0d go=%0d",
               nm, speedX, speedY, ballOnBat, livesLeft, gameOver,
               ex, ey, eob, el, ego);
    end
  endtask

  task automatic lost_wait(input int lives);
    for (int f = 1; f <= 60; f++) begin
      step(1, 0, 0, 0, 1, 0);
      chk($sformatf("lost_f%0d", f), 0, 0,
          (f == 60) ? 1 : 0, lives, 0);
    end
  endtask

  initial begin
    int mag;
    int hits;
    int ey;

    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 3, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 2, -3, 0, 3, 0));
    vecs.push_back(pv(0, 5'b10010, 1, 2, -3));
    vecs.push_back(pv(1, 0, 0, -4, -2));
    vecs.push_back(pv(0, 0, 6, -4, -2));
    vecs.push_back(pv(1, 0, 0, 3, -3));
    vecs.push_back(pv(0, 5'b11000, 0, 3, -3));
    vecs.push_back(pv(0, 5'b10100, 0, 3, -3));
    vecs.push_back(pv(1, 0, 0, -3, -3));
    vecs.push_back(pv(0, 5'b10001, 0, -3, -3));
    vecs.push_back(pv(1, 0, 0, -3, 3));
    vecs.push_back(pv(0, 5'b01010, 0, -3, 3));
    vecs.push_back(pv(1, 0, 0, -3, 3));
    vecs.push_back(pv(1, 5'b11000, 0, -3, 3));
    vecs.push_back(pv(1, 0, 0, 3, 3));
    vecs.push_back(pv(0, 5'b10011, 0, 3, 3));
    vecs.push_back(pv(1, 0, 0, 3, -3));
    vecs.push_back(pv(0, 0, 7, 3, -3));
    vecs.push_back(pv(0, 0, 0, 3, -3));
    vecs.push_back(pv(1, 0, 0, 4, -2));
    vecs.push_back(pv(0, 0, 3, 4, -2));
    vecs.push_back(pv(0, 0, 2, 4, -2));
    vecs.push_back(pv(1, 0, 0, -3, -3));
    vecs.push_back(pv(0, 0, 2, -3, -3));
    vecs.push_back(pv(0, 0, 3, -3, -3));
    vecs.push_back(pv(1, 0, 0, -2, -4));
    vecs.push_back(pv(0, 0, 5, -2, -4));
    vecs.push_back(pv(1, 0, 0, 2, -4));
    vecs.push_back(pv(0, 5'b10100, 0, 2, -4));
    vecs.push_back(pv(1, 0, 0, -2, -4));
    vecs.push_back(pv(0, 5'b11000, 0, -2, -4));
    vecs.push_back(pv(1, 0, 0, 2, -4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, -4, 0, 3, 0));

    #3 resetN = 1'b0;
    #1 chk("reset", 0, 0, 1, 3, 0);
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].sof, vecs[i].ball, vecs[i].bat,
           vecs[i].lost, vecs[i].launch, vecs[i].ng);
      chk($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey,
          vecs[i].eob, vecs[i].el, vecs[i].ego);
    end

    @(negedge clk);
    #2 resetN = 1'b0;
    #1 chk("async_reset", 0, 0, 1, 3, 0);
    @(negedge clk);
    resetN = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    chk("after_reset", 0, 0, 1, 3, 0);

    step(1, 0, 0, 0, 1, 0);
    chk("relaunch", 2, -3, 0, 3, 0);
    mag  = 3;
    hits = 0;
    for (int k = 1; k <= 40; k++) begin
      step(0, 0, 4, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      ey = (mag + 1 > 7) ? 7 : mag + 1;
      chk($sformatf("speedup_%0d", k), 0, -ey, 0, 3, 0);
      checks++;
      if (speedY < -11'sd7 || speedY > 11'sd7) begin
        errors++;
        $display("FAIL speedup_bound_%0d: got y=%0d want |y|<=7",
                 k, speedY);
      end
      hits++;
      if (hits == 8) begin
        hits = 0;
        if (mag < 7) mag++;
      end
    end

    step(0, 0, 0, 1, 0, 0);
    chk("loss1", 0, 0, 0, 2, 0);
    lost_wait(2);
    step(0, 0, 0, 1, 0, 0);
    chk("serve_lost_ignored", 0, 0, 1, 2, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("launch2", 2, -3, 0, 2, 0);
    step(0, 5'b10100, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("loss2", 0, 0, 0, 1, 0);
    lost_wait(1);
    step(1, 0, 0, 0, 1, 0);
    chk("launch3", 2, -3, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("latch_discarded", 2, -3, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("loss3_gameover", 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 0);
    chk("gameover_hold", 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("new_game", 0, 0, 1, 3, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("new_game_launch", 2, -3, 0, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
